// File: rtl/cla_result_buffer.sv
// Result buffer behind a fixed-latency pipelined adder: aligns valid flags,
// captures {cout,sum} with derived status flags into a credit-guarded FIFO.
// Ports: clk, rst (sync, active-high); issue_valid/issue_ready, a_msb, b_msb
// on the issue side; sum, cout from the adder; out_* ready/valid head; count.
module cla_result_buffer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     a_msb,
  input  logic                     b_msb,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int EW = WIDTH + 4;

  logic [LATENCY-1:0] v_q, v_d;
  logic [LATENCY-1:0] am_q, am_d;
  logic [LATENCY-1:0] bm_q, bm_d;
  logic [IW-1:0]      infl_q, infl_d;
  logic [PW-1:0]      wp_q, wp_d;
  logic [PW-1:0]      rp_q, rp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]      mem_q [DEPTH];

  logic acc, wr, pop;
  logic zero_w, neg_w, ovf_w;
  logic [EW-1:0] ent_w, head;

  // Credits count both queued and in-flight results, so a slot is
  // always reserved before the adder is allowed to start an operation.
  assign issue_ready = ({1'b0, cnt_q} + SW'(infl_q)) < SW'(DEPTH);
  assign acc = issue_valid && issue_ready;
  assign wr  = v_q[LATENCY-1];
  assign out_valid = cnt_q != '0;
  assign pop = out_valid && out_ready;

  assign zero_w = sum == '0;
  assign neg_w  = sum[WIDTH-1];
  assign ovf_w  = (am_q[LATENCY-1] == bm_q[LATENCY-1]) &&
                  (sum[WIDTH-1] != am_q[LATENCY-1]);
  assign ent_w  = {ovf_w, neg_w, zero_w, cout, sum};

  assign head     = mem_q[rp_q];
  assign out_sum  = head[WIDTH-1:0];
  assign out_cout = head[WIDTH];
  assign out_zero = head[WIDTH+1];
  assign out_neg  = head[WIDTH+2];
  assign out_ovf  = head[WIDTH+3];
  assign count    = cnt_q;

  always_comb begin
    v_d     = '0;
    am_d    = '0;
    bm_d    = '0;
    v_d[0]  = acc;
    am_d[0] = a_msb;
    bm_d[0] = b_msb;
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i]  = v_q[i-1];
      am_d[i] = am_q[i-1];
      bm_d[i] = bm_q[i-1];
    end
    infl_d = infl_q;
    if (acc && !wr) infl_d = infl_q + IW'(1);
    else if (!acc && wr) infl_d = infl_q - IW'(1);
    cnt_d = cnt_q;
    if (wr && !pop) cnt_d = cnt_q + CW'(1);
    else if (!wr && pop) cnt_d = cnt_q - CW'(1);
    wp_d = wr ? wp_q + PW'(1) : wp_q;
    rp_d = pop ? rp_q + PW'(1) : rp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      am_q   <= '0;
      bm_q   <= '0;
      infl_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      v_q    <= v_d;
      am_q   <= am_d;
      bm_q   <= bm_d;
      infl_q <= infl_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      if (wr) mem_q[wp_q] <= ent_w;
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(wr && cnt_q == CW'(DEPTH)));
  end

endmodule

// File: tb/tb_cla_result_buffer.sv
// Bench for cla_result_buffer: adder stub, queue-based reference model,
// per-cycle compare plus directed literal expectations.
module tb_cla_result_buffer;

  logic        clk = 0;
  logic        rst = 0;
  logic        issue_valid = 0;
  logic        issue_ready;
  logic        a_msb, b_msb;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_sum;
  logic        out_cout, out_zero, out_neg, out_ovf;
  logic [3:0]  count;

  logic [31:0] a_op = 0, b_op = 0;
  logic        cin_op = 0;

  always #5 clk = ~clk;

  cla_result_buffer #(.WIDTH(32), .LATENCY(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .a_msb(a_msb), .b_msb(b_msb),
    .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
    .count(count)
  );

  assign a_msb = a_op[31];
  assign b_msb = b_op[31];

  // Adder stand-in: four-stage pipe, result on its output before edge k+4.
  logic [32:0] apipe [4];
  initial for (int i = 0; i < 4; i++) apipe[i] = '0;
  always @(posedge clk) begin
    apipe[3] <= apipe[2];
    apipe[2] <= apipe[1];
    apipe[1] <= apipe[0];
    apipe[0] <= {1'b0, a_op} + {1'b0, b_op} + {32'd0, cin_op};
  end
  assign {cout, sum} = apipe[3];

  int checks = 0;
  int passes = 0;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
  endtask

  typedef struct {
    logic [32:0] r;
    logic        am;
    logic        bm;
    int          due;
  } ent_t;

  ent_t pend[$];
  ent_t mq[$];
  int   edge_n = 0;
  bit   started = 0;
  bit   m_rdy;
  ent_t ne;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      mq.delete();
      started = 1;
    end else begin
      m_rdy = (mq.size() + pend.size()) < 8;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == edge_n)
        mq.push_back(pend.pop_front());
      if (issue_valid && m_rdy) begin
        ne.r   = {1'b0, a_op} + {1'b0, b_op} + {32'd0, cin_op};
        ne.am  = a_op[31];
        ne.bm  = b_op[31];
        ne.due = edge_n + 4;
        pend.push_back(ne);
      end
    end
    edge_n++;
  end

  ent_t h;
  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      chk("m_count", {60'd0, count}, 64'(mq.size()));
      chk("m_ready", {63'd0, issue_ready},
          {63'd0, (mq.size() + pend.size()) < 8});
      if (mq.size() != 0) begin
        h = mq[0];
        chk("m_sum", {32'd0, out_sum}, {32'd0, h.r[31:0]});
        chk("m_cout", {63'd0, out_cout}, {63'd0, h.r[32]});
        chk("m_zero", {63'd0, out_zero}, {63'd0, h.r[31:0] == 0});
        chk("m_neg", {63'd0, out_neg}, {63'd0, h.r[31]});
        chk("m_ovf", {63'd0, out_ovf},
            {63'd0, (h.am == h.bm) && (h.r[31] != h.am)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, logic c);
    a_op = a;
    b_op = b;
    cin_op = c;
    issue_valid = 1;
  endtask

  task automatic idle();
    issue_valid = 0;
    a_op = $urandom;
    b_op = $urandom;
    cin_op = 1'($urandom);
  endtask

  int nacc, cyc, maxcnt, nout;
  bit pat [6];

  initial begin
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_valid", {63'd0, out_valid}, 0);
    chk("rst_count", {60'd0, count}, 0);
    chk("rst_ready", {63'd0, issue_ready}, 1);
    chk("rst_sum", {32'd0, out_sum}, 0);
    chk("rst_flags", {60'd0, out_cout, out_zero, out_neg, out_ovf}, 0);

    // T1: all-ones plus all-ones plus carry-in
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    step();
    idle();
    repeat (3) step();
    chk("t1_early", {63'd0, out_valid}, 0);
    step();
    chk("t1_valid", {63'd0, out_valid}, 1);
    chk("t1_sum", {32'd0, out_sum}, 64'hFFFFFFFF);
    chk("t1_flags", {60'd0, out_cout, out_zero, out_neg, out_ovf}, 64'b1010);
    out_ready = 1;
    step();
    chk("t1_pop", {60'd0, count}, 0);

    // T2: back-to-back overflow / carry / zero cases
    issue(32'h7FFFFFFF, 32'h00000001, 0);
    step();
    issue(32'h80000000, 32'h80000000, 0);
    step();
    issue(32'h00000000, 32'h00000000, 0);
    step();
    idle();
    step();
    step();
    chk("t2a_sum", {32'd0, out_sum}, 64'h80000000);
    chk("t2a_flags", {60'd0, out_cout, out_zero, out_neg, out_ovf}, 64'b0011);
    step();
    chk("t2b_sum", {32'd0, out_sum}, 0);
    chk("t2b_flags", {60'd0, out_cout, out_zero, out_neg, out_ovf}, 64'b1101);
    step();
    chk("t2c_valid", {63'd0, out_valid}, 1);
    chk("t2c_flags", {60'd0, out_cout, out_zero, out_neg, out_ovf}, 64'b0100);
    step();

    // T3: fill with consumer stalled
    out_ready = 0;
    nacc = 0;
    maxcnt = 0;
    repeat (16) begin
      issue($urandom, $urandom, 1'($urandom));
      if (issue_ready) nacc++;
      step();
      if (int'(count) > maxcnt) maxcnt = int'(count);
    end
    idle();
    chk("t3_accepted", 64'(nacc), 8);
    chk("t3_count", {60'd0, count}, 8);
    chk("t3_ready", {63'd0, issue_ready}, 0);
    chk("t3_max", 64'(maxcnt), 8);
    out_ready = 1;
    repeat (12) step();
    chk("t3_drain", {60'd0, count}, 0);

    // T4: random issues with toggling backpressure, pointers wrap
    nacc = 0;
    cyc = 0;
    while (nacc < 20 && cyc < 400) begin
      out_ready = 1'($urandom);
      if ($urandom_range(3) != 0) issue($urandom, $urandom, 1'($urandom));
      else idle();
      if (issue_valid && issue_ready) nacc++;
      step();
      cyc++;
    end
    idle();
    chk("t4_issued", 64'(nacc), 20);
    out_ready = 1;
    repeat (16) step();
    chk("t4_drain", {60'd0, count}, 0);

    // T5: bubbles
    pat = '{1, 0, 1, 0, 0, 1};
    nout = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 6 && pat[i]) issue($urandom, $urandom, 1'($urandom));
      else idle();
      step();
      if (out_valid) nout++;
    end
    chk("t5_outputs", 64'(nout), 3);

    // T6: reset with results queued and in flight
    out_ready = 0;
    repeat (5) begin
      issue($urandom, $urandom, 1'($urandom));
      step();
    end
    idle();
    step();
    chk("t6_queued", {60'd0, count}, 2);
    rst = 1;
    step();
    rst = 0;
    chk("t6_valid", {63'd0, out_valid}, 0);
    chk("t6_count", {60'd0, count}, 0);
    chk("t6_ready", {63'd0, issue_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_stale", {59'd0, out_valid, count}, 0);
    end
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
